// File: rtl/mux_wd_pkg.sv
// Shared constants for the registered write-data select: source indices and
// the built-in constant returned on index 0.
package mux_wd_pkg;

   localparam int unsigned SRC_CONST  = 0;
   localparam int unsigned SRC_ALUOUT = 1;
   localparam int unsigned SRC_MEM    = 2;
   localparam int unsigned SRC_MDR    = 3;
   localparam int unsigned SRC_HI     = 4;
   localparam int unsigned SRC_LO     = 5;
   localparam int unsigned SRC_SHIFT  = 6;
   localparam int unsigned SRC_PC4    = 7;

   localparam int unsigned CONST_227  = 227;

endpackage

// File: rtl/mux_wd_pipe_if.sv
// Write-back bus: upstream offer, register-file port and forwarding lookup.
// master drives the request side, slave is the mux_wd_pipe block.
interface mux_wd_pipe_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N_SRC  = 8,
   parameter int unsigned SEL_W  = 4,
   parameter int unsigned ADDR_W = 5
);

   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        sel;
   logic [N_SRC*DATA_W-1:0] src_data;
   logic [ADDR_W-1:0]       in_addr;
   logic                    in_we;

   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_W-1:0]       wd_data;
   logic [ADDR_W-1:0]       wd_addr;
   logic                    wd_we;

   logic [ADDR_W-1:0]       fwd_addr;
   logic                    fwd_hit;
   logic [DATA_W-1:0]       fwd_data;

   logic                    sel_err;

   modport master (
      output in_valid, sel, src_data, in_addr, in_we, out_ready, fwd_addr,
      input  in_ready, out_valid, wd_data, wd_addr, wd_we, fwd_hit, fwd_data, sel_err
   );

   modport slave (
      input  in_valid, sel, src_data, in_addr, in_we, out_ready, fwd_addr,
      output in_ready, out_valid, wd_data, wd_addr, wd_we, fwd_hit, fwd_data, sel_err
   );

endinterface

// File: rtl/wd_skid_buffer.sv
// Two-entry FIFO (head + skid) with valid/ready on both sides; all payload
// storage of the write-back pipe lives here.
module wd_skid_buffer #(
   parameter int unsigned W = 38
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data,
   output logic         skid_valid,
   output logic [W-1:0] skid_data
);

   logic [W-1:0] head_q, head_d, skid_q, skid_d;
   logic         head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
   logic         ready_q, ready_d;
   logic         push, pop;

   assign push = push_valid && ready_q;
   assign pop  = head_valid_q && pop_ready;

   always_comb begin
      head_d       = head_q;
      head_valid_d = head_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (!head_valid_q) begin
         if (push) begin
            head_d       = push_data;
            head_valid_d = 1'b1;
         end
      end else if (!skid_valid_q) begin
         if (push && pop) begin
            head_d = push_data;
         end else if (push) begin
            skid_d       = push_data;
            skid_valid_d = 1'b1;
         end else if (pop) begin
            head_valid_d = 1'b0;
         end
      end else if (pop) begin
         // Full: ready is low, so only the skid-to-head move can happen.
         head_d       = skid_q;
         skid_valid_d = 1'b0;
      end
      ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q       <= '0;
         head_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         head_q       <= head_d;
         head_valid_q <= head_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
      end
   end

   assign push_ready = ready_q;
   assign pop_valid  = head_valid_q;
   assign pop_data   = head_q;
   assign skid_valid = skid_valid_q;
   assign skid_data  = skid_q;

endmodule

// File: rtl/mux_wd_pipe.sv
// Registered register-file write-data select: source mux, zero-register rule,
// sticky select error and forwarding lookup in front of a 2-entry skid buffer.
module mux_wd_pipe
   import mux_wd_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned N_SRC     = 8,
   parameter int unsigned SEL_W     = 4,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned CONST_VAL = CONST_227
) (
   input logic           clk,
   input logic           reset,
   mux_wd_pipe_if.slave  bus
);

   localparam int unsigned PW = DATA_W + ADDR_W + 1;

   logic [DATA_W-1:0] sel_data;
   logic              sel_oor;
   logic              cap_we;
   logic [PW-1:0]     push_data, head, skid;
   logic              head_valid, skid_valid;
   logic              accept;
   logic              sel_err_q;
   logic              hit;
   logic [DATA_W-1:0] hit_data;
   logic              unused_src0;

   // Slice 0 is replaced by the built-in constant.
   assign unused_src0 = ^bus.src_data[DATA_W-1:0];

   always_comb begin
      sel_data = '0;
      sel_oor  = 1'b1;
      if (bus.sel == '0) begin
         sel_data = DATA_W'(CONST_VAL);
         sel_oor  = 1'b0;
      end
      for (int unsigned i = 1; i < N_SRC; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            sel_data = bus.src_data[i*DATA_W +: DATA_W];
            sel_oor  = 1'b0;
         end
      end
   end

   assign cap_we    = bus.in_we && (bus.in_addr != '0);
   assign push_data = {sel_data, bus.in_addr, cap_we};
   assign accept    = bus.in_valid && bus.in_ready;

   wd_skid_buffer #(
      .W (PW)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push_valid (bus.in_valid),
      .push_ready (bus.in_ready),
      .push_data  (push_data),
      .pop_valid  (head_valid),
      .pop_ready  (bus.out_ready),
      .pop_data   (head),
      .skid_valid (skid_valid),
      .skid_data  (skid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_err_q <= 1'b0;
      end else if (accept && sel_oor) begin
         sel_err_q <= 1'b1;
      end
   end

   // Skid is the younger entry, so it is checked last and overrides the head.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      if (bus.fwd_addr != '0) begin
         if (head_valid && head[0] && (head[ADDR_W:1] == bus.fwd_addr)) begin
            hit      = 1'b1;
            hit_data = head[PW-1 -: DATA_W];
         end
         if (skid_valid && skid[0] && (skid[ADDR_W:1] == bus.fwd_addr)) begin
            hit      = 1'b1;
            hit_data = skid[PW-1 -: DATA_W];
         end
      end
   end

   assign bus.out_valid = head_valid;
   assign bus.wd_data   = head[PW-1 -: DATA_W];
   assign bus.wd_addr   = head[ADDR_W:1];
   assign bus.wd_we     = head[0] && head_valid;
   assign bus.fwd_hit   = hit;
   assign bus.fwd_data  = hit_data;
   assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_wd_pipe.sv
// Self-checking bench for mux_wd_pipe: vector table, hand-written buffer and
// reset sequences, then randomized traffic against a queue-based model.
module tb_mux_wd_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_wd_pipe_if #(.DATA_W(32), .N_SRC(8), .SEL_W(4), .ADDR_W(5)) bus ();
   mux_wd_pipe_if #(.DATA_W(32), .N_SRC(6), .SEL_W(4), .ADDR_W(5)) bus6 ();

   mux_wd_pipe #(.DATA_W(32), .N_SRC(8), .SEL_W(4), .ADDR_W(5), .CONST_VAL(227)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   mux_wd_pipe #(.DATA_W(32), .N_SRC(6), .SEL_W(4), .ADDR_W(5), .CONST_VAL(227)) dut6 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus6.slave)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  sel;
      logic [4:0]  addr;
      logic        we;
      logic [31:0] exp_data;
      logic [4:0]  exp_addr;
      logic        exp_we;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        we;
   } ent_t;

   vec_t vecs[$];
   ent_t q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_sel(input logic [3:0] s, input logic [255:0] src);
      if (s == 4'd0) return 32'd227;
      if (s < 4'd8) return src[s*32 +: 32];
      return 32'd0;
   endfunction

   task automatic idle_inputs();
      bus.in_valid   = 1'b0;  bus.sel  = '0; bus.src_data  = '0; bus.in_addr  = '0;
      bus.in_we      = 1'b0;  bus.out_ready  = 1'b0; bus.fwd_addr  = '0;
      bus6.in_valid  = 1'b0;  bus6.sel = '0; bus6.src_data = '0; bus6.in_addr = '0;
      bus6.in_we     = 1'b0;  bus6.out_ready = 1'b0; bus6.fwd_addr = '0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      vec_t        v;
      ent_t        e;
      logic        exp_hit;
      logic [31:0] exp_fd;
      logic        model_err;
      logic        acc, pop;

      idle_inputs();
      reset = 1'b0;
      #12;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_wd_data", bus.wd_data, 32'd0);
      chk("rst_wd_addr", bus.wd_addr, 5'd0);
      chk("rst_wd_we", bus.wd_we, 1'b0);
      chk("rst_sel_err", bus.sel_err, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // ---------------- vector table, back-to-back with out_ready=1
      vecs.push_back('{4'd0, 5'd8, 1'b1, 32'd227, 5'd8, 1'b1, 1'b0});
      for (int i = 1; i < 8; i++)
         vecs.push_back('{4'(i), 5'(i), 1'b1, 32'h1000_0000 + 32'(i), 5'(i), 1'b1, 1'b0});
      vecs.push_back('{4'd1, 5'd0, 1'b1, 32'h1000_0001, 5'd0, 1'b0, 1'b0});
      vecs.push_back('{4'd2, 5'd5, 1'b0, 32'h1000_0002, 5'd5, 1'b0, 1'b0});
      vecs.push_back('{4'd8, 5'd9, 1'b1, 32'd0, 5'd9, 1'b1, 1'b1});

      for (int i = 0; i < 8; i++) bus.src_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      bus.out_ready = 1'b1;
      for (int j = 0; j <= vecs.size(); j++) begin
         @(negedge clk);
         if (j > 0) begin
            v = vecs[j-1];
            bus.fwd_addr = v.addr;
            #1;
            chk("tbl_out_valid", bus.out_valid, 1'b1);
            chk("tbl_wd_data", bus.wd_data, v.exp_data);
            chk("tbl_wd_addr", bus.wd_addr, v.exp_addr);
            chk("tbl_wd_we", bus.wd_we, v.exp_we);
            chk("tbl_in_ready", bus.in_ready, 1'b1);
            chk("tbl_sel_err", bus.sel_err, v.exp_err);
            chk("tbl_fwd_hit", bus.fwd_hit, v.exp_we);
            chk("tbl_fwd_data", bus.fwd_data, v.exp_we ? v.exp_data : 32'd0);
         end
         if (j < vecs.size()) begin
            bus.in_valid = 1'b1;
            bus.sel      = vecs[j].sel;
            bus.in_addr  = vecs[j].addr;
            bus.in_we    = vecs[j].we;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("tbl_drained", bus.out_valid, 1'b0);
      chk("tbl_err_sticky", bus.sel_err, 1'b1);

      // ---------------- fill head+skid with same address, forward youngest
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1; bus.sel = 4'd1; bus.in_addr = 5'd3; bus.in_we = 1'b1;
      bus.src_data[32 +: 32] = 32'hAAAA_0001;
      @(negedge clk);
      bus.fwd_addr = 5'd3;
      #1;
      chk("skid_a_valid", bus.out_valid, 1'b1);
      chk("skid_a_ready", bus.in_ready, 1'b1);
      chk("skid_a_fwd", bus.fwd_data, 32'hAAAA_0001);
      bus.src_data[32 +: 32] = 32'hBBBB_0002;
      @(negedge clk);
      #1;
      chk("skid_full_ready", bus.in_ready, 1'b0);
      chk("skid_hold_data", bus.wd_data, 32'hAAAA_0001);
      chk("skid_fwd_hit", bus.fwd_hit, 1'b1);
      chk("skid_fwd_young", bus.fwd_data, 32'hBBBB_0002);
      bus.in_valid = 1'b1;  // ignored while full
      bus.src_data[32 +: 32] = 32'hCCCC_0003;
      @(negedge clk);
      chk("skid_stall_data", bus.wd_data, 32'hAAAA_0001);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("skid_b_head", bus.wd_data, 32'hBBBB_0002);
      chk("skid_b_valid", bus.out_valid, 1'b1);
      chk("skid_ready_back", bus.in_ready, 1'b1);
      @(negedge clk);
      chk("skid_empty", bus.out_valid, 1'b0);
      bus.fwd_addr = 5'd3;
      #1;
      chk("skid_empty_fwd", bus.fwd_hit, 1'b0);

      // ---------------- mid-operation asynchronous reset with two entries held
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1; bus.sel = 4'd2; bus.in_addr = 5'd7; bus.in_we = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("mr_full", bus.in_ready, 1'b0);
      chk("mr_we_before", bus.wd_we, 1'b1);
      chk("mr_err_before", bus.sel_err, 1'b1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mr_out_valid", bus.out_valid, 1'b0);
      chk("mr_wd_we", bus.wd_we, 1'b0);
      chk("mr_wd_data", bus.wd_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mr_in_ready", bus.in_ready, 1'b1);
      chk("mr_sel_err", bus.sel_err, 1'b0);
      chk("mr_still_empty", bus.out_valid, 1'b0);

      // ---------------- N_SRC=6 instance: sel=7 out of range, sticky error
      bus6.out_ready = 1'b1;
      bus6.in_valid  = 1'b1; bus6.sel = 4'd7; bus6.in_addr = 5'd4; bus6.in_we = 1'b1;
      bus6.src_data  = {6{32'hDEAD_BEEF}};
      @(negedge clk);
      chk("n6_valid", bus6.out_valid, 1'b1);
      chk("n6_oor_data", bus6.wd_data, 32'd0);
      chk("n6_err_set", bus6.sel_err, 1'b1);
      bus6.sel = 4'd5; bus6.src_data[160 +: 32] = 32'h0000_1234;
      @(negedge clk);
      bus6.in_valid = 1'b0;
      chk("n6_legal_data", bus6.wd_data, 32'h0000_1234);
      chk("n6_err_holds", bus6.sel_err, 1'b1);
      @(negedge clk);
      chk("n6_err_holds2", bus6.sel_err, 1'b1);
      reset_pulse();
      chk("n6_err_cleared", bus6.sel_err, 1'b0);

      // ---------------- randomized traffic against the FIFO model
      q.delete();
      model_err = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         chk("rnd_out_valid", bus.out_valid, q.size() > 0);
         chk("rnd_in_ready", bus.in_ready, q.size() < 2);
         chk("rnd_sel_err", bus.sel_err, model_err);
         if (q.size() > 0) begin
            chk("rnd_wd_data", bus.wd_data, q[0].data);
            chk("rnd_wd_addr", bus.wd_addr, q[0].addr);
            chk("rnd_wd_we", bus.wd_we, q[0].we);
         end
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.sel       = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(8, 15))
                                                      : 4'($urandom_range(0, 7));
         for (int w = 0; w < 8; w++) bus.src_data[w*32 +: 32] = $urandom;
         bus.in_addr   = 5'($urandom_range(0, 3));
         bus.in_we     = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.fwd_addr  = 5'($urandom_range(0, 3));
         #1;
         exp_hit = 1'b0;
         exp_fd  = 32'd0;
         foreach (q[k]) begin
            if (q[k].we && q[k].addr == bus.fwd_addr && bus.fwd_addr != 5'd0) begin
               exp_hit = 1'b1;
               exp_fd  = q[k].data;
            end
         end
         chk("rnd_fwd_hit", bus.fwd_hit, exp_hit);
         chk("rnd_fwd_data", bus.fwd_data, exp_fd);
         @(posedge clk);
         acc = bus.in_valid && (q.size() < 2);
         pop = (q.size() > 0) && bus.out_ready;
         e.data = ref_sel(bus.sel, bus.src_data);
         e.addr = bus.in_addr;
         e.we   = bus.in_we && (bus.in_addr != 5'd0);
         if (pop) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            if (bus.sel >= 4'd8) model_err = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_wd_pipe.md
Name: mux_wd_pipe

Overview:
- Parametrised, registered successor to the register-file write-data select.
- Selects one of N_SRC write-back sources, or the built-in constant on index 0, and captures it with destination address and write enable.
- Delivers the result through a valid/ready handshake with a 2-entry skid buffer.
- Exposes a forwarding lookup over in-flight entries. It sits between the datapath source registers (ALUOut, MDR, HI, LO, shifter, PC+4, memory) and the register-file write port.

Parameters:
- DATA_W, 32, width of every source and of the write data.
- N_SRC, 8, number of select indices, constant included; legal range 2..16.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= N_SRC.
- ADDR_W, 5, register-file address width.
- CONST_VAL, 227, value returned for select index 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers a write-back.
- in_ready  out  1  block can accept; registered.
- sel  in  SEL_W  source index.
- src_data  in  N_SRC*DATA_W  flattened sources; slice i = source i; slice 0 ignored.
- in_addr  in  ADDR_W  destination register.
- in_we  in  1  write requested.
- out_valid  out  1  head entry present.
- out_ready  in  1  register file consumes the head.
- wd_data  out  DATA_W  head write data.
- wd_addr  out  ADDR_W  head destination.
- wd_we  out  1  head write enable.
- fwd_addr  in  ADDR_W  forwarding query address.
- fwd_hit  out  1  an in-flight entry writes fwd_addr.
- fwd_data  out  DATA_W  data of the youngest matching entry.
- sel_err  out  1  sticky: an out-of-range select was accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - both entries become invalid;
  - in_ready=1, out_valid=0, wd_data=0, wd_addr=0, wd_we=0, sel_err=0.
- Accept: the transfer happens when in_valid && in_ready at a rising edge. The selected value is computed combinationally and captured that edge.
  - sel==0 → CONST_VAL.
  - 1<=sel<N_SRC → src_data slice sel.
  - sel>=N_SRC → 0, and sel_err is set; it holds until reset.
- Zero-register rule: captured we = in_we && (in_addr != 0). The data is still stored.
- Latency: on an empty block, an input accepted at edge k gives out_valid=1 with its data from edge k onward (1 cycle).
- Buffer: a head register and a skid register, strict FIFO order.
  - in_ready = !skid_valid, registered.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop with 1 entry: the head is replaced by the new entry; skid stays empty.
  - Simultaneous push and pop with 2 entries: impossible, because in_ready=0.
  - Pop with 2 entries: skid moves to head; in_ready returns to 1 the next cycle.
  - Push with 1 entry and no pop: goes to skid; in_ready drops the next cycle.
- Outputs are all registered; wd_* hold stable while out_valid && !out_ready.
- Forwarding (combinational on fwd_addr):
  - A hit requires a valid entry with we=1 and addr==fwd_addr.
  - fwd_addr==0 never hits.
  - When both entries match, the skid (younger) wins.
  - On a miss, fwd_data=0.
  - The entry accepted this edge is not visible until the next cycle.
- Mid-operation reset: clears all entries immediately and drops pending data. No partial write is emitted; wd_we=0 asynchronously.

Decomposition:
- Package mux_wd_pkg holds:
  - source index constants: SRC_CONST=0, SRC_ALUOUT=1, SRC_MEM=2, SRC_MDR=3, SRC_HI=4, SRC_LO=5, SRC_SHIFT=6, SRC_PC4=7;
  - CONST_227.
- Sub-module wd_skid_buffer (2-entry, payload {data, addr, we}, valid/ready both sides) holds all sequential storage. The top holds the select logic, the zero-register rule, sel_err and the forwarding compare.

Test Plan:
- Reset, then sel=0, in_addr=8, in_we=1, one accept, out_ready=1 → next cycle wd_data=227, wd_addr=8, wd_we=1; then out_valid=0.
- Sweep sel=1..7 with source i = 0x1000_0000+i, continuous in_valid and out_ready=1 → one output per cycle, in order, data 0x1000_0001..0x1000_0007; in_ready stays 1.
- out_ready=0, push A(addr 3) and B(addr 3) → in_ready=0 after the second push; fwd_addr=3 gives fwd_hit=1 with B's data; release out_ready → A then B appear; in_ready returns to 1.
- in_addr=0, in_we=1, sel=1 → wd_we=0; fwd_addr=0 gives fwd_hit=0.
- N_SRC=6, sel=7 → wd_data=0, sel_err=1, which persists across later legal transfers until reset.
- Two entries buffered, assert reset mid-cycle → out_valid=0, wd_we=0 immediately; after release in_ready=1 and sel_err=0.
